// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and SPI mode constants for the master engine
package spi_pkg;

    // Mode 0 only: SCLK idles low, data captured on the rising edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_LEAD,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_PUSH,
        ST_TRAIL
    } spi_state_t;

    // States whose length is set by the SCLK divider rather than being a single cycle.
    function automatic logic is_timed(input spi_state_t st);
        return (st == ST_LEAD) || (st == ST_SHIFT_HI) ||
               (st == ST_SHIFT_LO) || (st == ST_TRAIL);
    endfunction

endpackage

// File: rtl/spi_master_engine_if.sv
// rtl/spi_master_engine_if.sv - FIFO-side and pin-side signal bundle of the SPI master engine
interface spi_master_engine_if #(
    parameter int DWIDTH = 8
);
    logic              tx_empty;
    logic              tx_pop;
    logic [DWIDTH-1:0] tx_data;
    logic              rx_full;
    logic              rx_push;
    logic [DWIDTH-1:0] rx_data;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              cs_n;
    logic              busy;
    logic              rx_overrun;
    logic              ovr_clr;

    modport master (
        input  tx_empty,
        output tx_pop,
        input  tx_data,
        input  rx_full,
        output rx_push,
        output rx_data,
        output sclk,
        output mosi,
        input  miso,
        output cs_n,
        output busy,
        output rx_overrun,
        input  ovr_clr
    );

    modport slave (
        output tx_empty,
        input  tx_pop,
        output tx_data,
        output rx_full,
        input  rx_push,
        input  rx_data,
        input  sclk,
        input  mosi,
        output miso,
        input  cs_n,
        input  busy,
        input  rx_overrun,
        output ovr_clr
    );

endinterface

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - loadable down-counter ticking phase_done once every CLK_DIV enabled cycles
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    output logic phase_done
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Reloading on the tick lets consecutive timed phases chain without a gap cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RELOAD;
        end else if (load || phase_done) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign phase_done = en && (cnt == '0);

endmodule

// File: rtl/spi_master_engine.sv
// rtl/spi_master_engine.sv - mode-0 SPI master draining the TX FIFO and filling the RX FIFO
module spi_master_engine
    import spi_pkg::*;
#(
    parameter int DWIDTH  = 8,
    parameter int CLK_DIV = 2
) (
    input logic              clk,
    input logic              rst,
    spi_master_engine_if.master bus
);

    localparam int BW = $clog2(DWIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH - 1);

    spi_state_t        state;
    spi_state_t        state_nxt;
    logic [DWIDTH-1:0] tx_sr;
    logic [DWIDTH-1:0] rx_sr;
    logic [BW-1:0]     bit_cnt;
    logic              sclk_q;
    logic              mosi_q;
    logic              cs_n_q;
    logic              overrun_q;
    logic              timed;
    logic              phase_done;
    logic              enter_hi;
    logic              enter_lo;
    logic              last_bit;

    assign timed    = is_timed(state);
    assign last_bit = (bit_cnt == LAST_BIT);

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .en        (timed),
        .load      (!timed),
        .phase_done(phase_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (!bus.tx_empty) state_nxt = ST_FETCH;
            ST_FETCH:    state_nxt = ST_LOAD;
            // A word following another one keeps CS_N low and skips the setup phase.
            ST_LOAD:     state_nxt = cs_n_q ? ST_LEAD : ST_SHIFT_HI;
            ST_LEAD:     if (phase_done) state_nxt = ST_SHIFT_HI;
            ST_SHIFT_HI: if (phase_done) state_nxt = ST_SHIFT_LO;
            ST_SHIFT_LO: if (phase_done) state_nxt = last_bit ? ST_PUSH : ST_SHIFT_HI;
            ST_PUSH:     state_nxt = bus.tx_empty ? ST_TRAIL : ST_FETCH;
            ST_TRAIL:    if (phase_done) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    assign enter_hi = (state_nxt == ST_SHIFT_HI) && (state != ST_SHIFT_HI);
    assign enter_lo = (state == ST_SHIFT_HI) && phase_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q  <= CPOL;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else begin
            sclk_q <= CPOL ^ (state_nxt == ST_SHIFT_HI);
            if (state == ST_LOAD) begin
                tx_sr   <= bus.tx_data;
                mosi_q  <= bus.tx_data[DWIDTH-1];
                cs_n_q  <= 1'b0;
                bit_cnt <= '0;
            end
            // tx_sr[DWIDTH-1] is the bit currently on MOSI; the next one sits just below it.
            if (enter_lo && !last_bit) begin
                mosi_q <= tx_sr[DWIDTH-2];
                tx_sr  <= tx_sr << 1;
            end
            if ((state == ST_SHIFT_LO) && phase_done && !last_bit) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (enter_hi) begin
                rx_sr <= {rx_sr[DWIDTH-2:0], bus.miso};
            end
            if ((state == ST_TRAIL) && phase_done) begin
                cs_n_q <= 1'b1;
            end
        end
    end

    // A blocked push in the same cycle as a clear must leave the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if ((state == ST_PUSH) && bus.rx_full) begin
            overrun_q <= 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.tx_pop     = (state == ST_FETCH);
    assign bus.rx_push    = (state == ST_PUSH) && !bus.rx_full;
    assign bus.rx_data    = rx_sr;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.sclk       = sclk_q;
    assign bus.mosi       = mosi_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.rx_overrun = overrun_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// tb/tb_spi_master_engine.sv - scoreboard bench for spi_master_engine at CLK_DIV=2 and CLK_DIV=1
module tb_spi_master_engine;

    typedef struct packed {
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic sel;

    always #5 clk = ~clk;

    spi_master_engine_if #(.DWIDTH(8)) ifa ();
    spi_master_engine_if #(.DWIDTH(8)) ifb ();

    spi_master_engine #(.DWIDTH(8), .CLK_DIV(2)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    spi_master_engine #(.DWIDTH(8), .CLK_DIV(1)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    int         vectors = 0;
    int         miscompares = 0;
    exp_t       expq[$];
    logic [7:0] txq_a[$];
    logic [7:0] txq_b[$];
    bit         misoq_a[$];
    bit         misoq_b[$];
    logic       prev_a = 1'b0;
    logic       prev_b = 1'b0;
    logic [7:0] mosi_a = 8'h00;
    logic [7:0] mosi_b = 8'h00;
    int         n_push_a = 0;
    int         n_push_b = 0;
    exp_t       e_a;
    exp_t       e_b;

    wire m_sclk = sel ? ifb.sclk    : ifa.sclk;
    wire m_cs   = sel ? ifb.cs_n    : ifa.cs_n;
    wire m_pop  = sel ? ifb.tx_pop  : ifa.tx_pop;
    wire m_push = sel ? ifb.rx_push : ifa.rx_push;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // TX FIFO, MISO slave and RX scoreboard for the CLK_DIV=2 instance
    always @(negedge clk) begin
        if (rst_a) begin
            txq_a.delete();
            misoq_a.delete();
            prev_a = 1'b0;
        end else begin
            if (ifa.sclk && !prev_a) begin
                mosi_a = {mosi_a[6:0], ifa.mosi};
                if (misoq_a.size() > 0) void'(misoq_a.pop_front());
            end
            prev_a = ifa.sclk;
            if (ifa.tx_pop) begin
                check("pop_nonempty_a", 32'(txq_a.size() != 0), 1);
                if (txq_a.size() != 0) ifa.tx_data = txq_a.pop_front();
            end
            if (ifa.rx_push) begin
                n_push_a++;
                check("push_expected_a", 32'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    e_a = expq.pop_front();
                    check("rx_data_a", 32'(ifa.rx_data), 32'(e_a.rx));
                    check("mosi_bits_a", 32'(mosi_a), 32'(e_a.tx));
                end
            end
        end
        ifa.tx_empty = (txq_a.size() == 0);
        ifa.miso     = (misoq_a.size() > 0) ? misoq_a[0] : 1'b0;
    end

    // Same models for the CLK_DIV=1 instance
    always @(negedge clk) begin
        if (rst_b) begin
            txq_b.delete();
            misoq_b.delete();
            prev_b = 1'b0;
        end else begin
            if (ifb.sclk && !prev_b) begin
                mosi_b = {mosi_b[6:0], ifb.mosi};
                if (misoq_b.size() > 0) void'(misoq_b.pop_front());
            end
            prev_b = ifb.sclk;
            if (ifb.tx_pop) begin
                check("pop_nonempty_b", 32'(txq_b.size() != 0), 1);
                if (txq_b.size() != 0) ifb.tx_data = txq_b.pop_front();
            end
            if (ifb.rx_push) begin
                n_push_b++;
                check("push_expected_b", 32'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    e_b = expq.pop_front();
                    check("rx_data_b", 32'(ifb.rx_data), 32'(e_b.rx));
                    check("mosi_bits_b", 32'(mosi_b), 32'(e_b.tx));
                end
            end
        end
        ifb.tx_empty = (txq_b.size() == 0);
        ifb.miso     = (misoq_b.size() > 0) ? misoq_b[0] : 1'b0;
    end

    task automatic send(input bit b, input logic [7:0] tx, input logic [7:0] rx, input bit will_push);
        if (will_push) expq.push_back({tx, rx});
        for (int i = 7; i >= 0; i--) begin
            if (b) misoq_b.push_back(rx[i]);
            else   misoq_a.push_back(rx[i]);
        end
        if (b) txq_b.push_back(tx);
        else   txq_a.push_back(tx);
    endtask

    // Cycle 0 is the first negedge showing TX_POP; runs until CS_N rises again.
    task automatic xfer(input int limit, output int t_rise, output int t_last, output int t_push,
                        output int t_csh, output int n_rise, output int n_pop, output int max_low);
        int   c;
        int   low;
        logic prev;
        bit   seen_low;
        t_rise = -1; t_last = -1; t_push = -1; t_csh = -1;
        n_rise = 0; n_pop = 0; max_low = 0;
        low = 0; prev = 1'b0; seen_low = 1'b0;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!m_pop && c < limit);
        if (!m_pop) begin
            check("pop_seen", 32'(m_pop), 1);
            return;
        end
        c = 0;
        while (c < limit) begin
            if (m_pop) n_pop++;
            if (m_push && t_push < 0) t_push = c;
            if (!m_cs) seen_low = 1'b1;
            if (m_sclk && !prev) begin
                if (t_rise < 0) t_rise = c;
                else if (low > max_low) max_low = low;
                t_last = c;
                n_rise++;
                low = 0;
            end
            if (!m_sclk) low++;
            if (seen_low && m_cs) begin
                t_csh = c;
                break;
            end
            prev = m_sclk;
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t_rise, t_last, t_push, t_csh, n_rise, n_pop, max_low;
        int viol, rises, c, n0;
        logic prev;

        sel = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.rx_full = 1'b0;
        ifa.ovr_clr = 1'b0;
        ifb.rx_full = 1'b0;
        ifb.ovr_clr = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cs_n", 32'(ifa.cs_n), 1);
        check("rst_sclk", 32'(ifa.sclk), 0);
        check("rst_mosi", 32'(ifa.mosi), 0);
        check("rst_tx_pop", 32'(ifa.tx_pop), 0);
        check("rst_rx_push", 32'(ifa.rx_push), 0);
        check("rst_busy", 32'(ifa.busy), 0);
        check("rst_rx_data", 32'(ifa.rx_data), 0);
        check("rst_overrun", 32'(ifa.rx_overrun), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifa.tx_pop || ifa.sclk || ifa.busy || !ifa.cs_n) viol++;
        end
        check("idle_quiet", viol, 0);

        send(1'b0, 8'hA5, 8'h3C, 1'b1);
        xfer(200, t_rise, t_last, t_push, t_csh, n_rise, n_pop, max_low);
        check("w1_first_rise", t_rise, 4);
        check("w1_push_cycle", t_push, 36);
        check("w1_cs_high", t_csh, 39);
        check("w1_rises", n_rise, 8);
        check("w1_pops", n_pop, 1);

        send(1'b0, 8'h12, 8'h81, 1'b1);
        send(1'b0, 8'h34, 8'h7E, 1'b1);
        xfer(300, t_rise, t_last, t_push, t_csh, n_rise, n_pop, max_low);
        check("b2b_pops", n_pop, 2);
        check("b2b_rises", n_rise, 16);
        check("b2b_gap", max_low, 5);
        check("b2b_cs_high", t_csh, 74);

        n0 = n_push_a;
        ifa.rx_full = 1'b1;
        send(1'b0, 8'hC3, 8'h55, 1'b0);
        xfer(200, t_rise, t_last, t_push, t_csh, n_rise, n_pop, max_low);
        check("ovr_set", 32'(ifa.rx_overrun), 1);
        check("ovr_no_push", n_push_a, n0);
        repeat (5) @(negedge clk);
        check("ovr_sticky", 32'(ifa.rx_overrun), 1);

        send(1'b0, 8'h0F, 8'hF0, 1'b0);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!ifa.tx_pop && c < 50);
        check("ovr2_pop_seen", 32'(ifa.tx_pop), 1);
        repeat (10) @(negedge clk);
        ifa.ovr_clr = 1'b1;
        @(negedge clk);
        ifa.ovr_clr = 1'b0;
        check("ovr_cleared", 32'(ifa.rx_overrun), 0);
        repeat (25) @(negedge clk);
        ifa.ovr_clr = 1'b1;
        @(negedge clk);
        ifa.ovr_clr = 1'b0;
        check("ovr_set_wins", 32'(ifa.rx_overrun), 1);
        repeat (5) @(negedge clk);
        ifa.rx_full = 1'b0;
        ifa.ovr_clr = 1'b1;
        @(negedge clk);
        ifa.ovr_clr = 1'b0;
        check("ovr_cleared2", 32'(ifa.rx_overrun), 0);
        check("ovr2_no_push", n_push_a, n0);

        n0 = n_push_a;
        send(1'b0, 8'h96, 8'h69, 1'b0);
        rises = 0;
        prev = 1'b0;
        c = 0;
        while (rises < 3 && c < 200) begin
            @(negedge clk);
            c++;
            if (ifa.sclk && !prev) rises++;
            prev = ifa.sclk;
        end
        check("rst_third_rise", rises, 3);
        rst_a = 1'b1;
        #1;
        check("mid_rst_cs_n", 32'(ifa.cs_n), 1);
        check("mid_rst_sclk", 32'(ifa.sclk), 0);
        check("mid_rst_busy", 32'(ifa.busy), 0);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_rst_no_push", n_push_a, n0);
        send(1'b0, 8'h5A, 8'hC3, 1'b1);
        xfer(200, t_rise, t_last, t_push, t_csh, n_rise, n_pop, max_low);
        check("post_rst_push", t_push, 36);
        check("post_rst_rises", n_rise, 8);

        sel = 1'b1;
        send(1'b1, 8'hFF, 8'hA6, 1'b1);
        xfer(100, t_rise, t_last, t_push, t_csh, n_rise, n_pop, max_low);
        check("div1_first_rise", t_rise, 3);
        check("div1_period_span", t_last - t_rise, 14);
        check("div1_low_run", max_low, 1);
        check("div1_push_cycle", t_push, 19);
        check("div1_cs_high", t_csh, 21);
        check("div1_pushes", n_push_b, 1);

        repeat (5) @(negedge clk);
        check("sb_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
